// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_controller_pkg;

  typedef struct packed {
    logic stall;
    logic flush;
  } control;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_TRAP   = 2'd2,
    PC_MRET   = 2'd3
  } pcSelect_;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } pipeCtlState_;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000000B;

  localparam control CTL_NONE  = '{stall: 1'b0, flush: 1'b0};
  localparam control CTL_FLUSH = '{stall: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipeline_controller_drain_timer.sv
// Counts cycles spent in DRAIN and flags expiry at DRAIN_TIMEOUT-1.
module drain_timer #(
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic count_en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(DRAIN_TIMEOUT + 1);

  logic [CW-1:0] drainCount_q, drainCount_d;

  always_comb begin
    drainCount_d = drainCount_q;
    if (clear_i)         drainCount_d = '0;
    else if (count_en_i) drainCount_d = drainCount_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) drainCount_q <= '0;
    else        drainCount_q <= drainCount_d;
  end

  assign expired_o = (drainCount_q == CW'(DRAIN_TIMEOUT - 1));

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer: redirect arbitration, trap/MRET sequencing and DRAIN timeout.
// Optional feature macro: PIPECTL_INTERRUPT_EN enables the external interrupt trap path.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        loadUseHazard,
  input  logic        branchValid,
  input  logic        mretSignal,
  input  logic        commitIllegal,
  input  logic [31:0] commitPC,
  input  logic        interrupt,
  input  logic        interruptEnabled,
  input  logic        imemReady,
  input  logic        dmemBusy,
  output control      fetchDecodeControl,
  output control      decodeExecuteControl,
  output control      executeMemoryControl,
  output control      memoryWritebackControl,
  output pcSelect_    pcSelect,
  output logic        redirectValid,
  output logic        trapCommit,
  output logic [31:0] trapCause,
  output logic [31:0] trapEPC,
  output logic        drainTimeout
);

  pipeCtlState_ state_q, state_d;
  logic         redirectHeld_q, redirectHeld_d;
  logic [31:0]  cause_q, cause_d;
  logic [31:0]  epc_q, epc_d;
  logic         timeout_q, timeout_d;
  logic         irq, trapReq, cntEn, cntClr, expired;

`ifdef PIPECTL_INTERRUPT_EN
  assign irq = interrupt & interruptEnabled;
`else
  logic unused_irq;
  assign unused_irq = interrupt ^ interruptEnabled;
  assign irq        = 1'b0;
`endif

  assign trapReq = commitIllegal | irq;

  drain_timer #(.DRAIN_TIMEOUT(DRAIN_TIMEOUT)) u_drain_timer (
    .clock      (clock),
    .reset      (reset),
    .count_en_i (cntEn),
    .clear_i    (cntClr),
    .expired_o  (expired)
  );

  always_comb begin
    state_d                = state_q;
    redirectHeld_d         = redirectHeld_q;
    cause_d                = cause_q;
    epc_d                  = epc_q;
    timeout_d              = timeout_q;
    fetchDecodeControl     = CTL_NONE;
    decodeExecuteControl   = CTL_NONE;
    executeMemoryControl   = CTL_NONE;
    memoryWritebackControl = CTL_NONE;
    pcSelect               = PC_SEQ;
    redirectValid          = 1'b0;
    trapCommit             = 1'b0;
    cntEn                  = 1'b0;
    cntClr                 = 1'b0;

    unique case (state_q)
      RUN: begin
        if (trapReq) begin
          cause_d                = commitIllegal ? CAUSE_ILLEGAL : CAUSE_MEI;
          epc_d                  = commitPC;
          fetchDecodeControl     = CTL_FLUSH;
          decodeExecuteControl   = CTL_FLUSH;
          executeMemoryControl   = CTL_FLUSH;
          memoryWritebackControl = CTL_FLUSH;
          redirectHeld_d         = 1'b0;
          state_d                = dmemBusy ? DRAIN : TRAP;
        end else begin
          // Redirects combine with the stall logic below; flush still wins per stage.
          if (mretSignal) begin
            pcSelect                   = PC_MRET;
            redirectValid              = 1'b1;
            fetchDecodeControl.flush   = 1'b1;
            decodeExecuteControl.flush = 1'b1;
          end else if (branchValid && !redirectHeld_q) begin
            pcSelect                   = PC_BRANCH;
            redirectValid              = 1'b1;
            fetchDecodeControl.flush   = 1'b1;
            decodeExecuteControl.flush = 1'b1;
          end
          if (dmemBusy) begin
            fetchDecodeControl.stall     = 1'b1;
            decodeExecuteControl.stall   = 1'b1;
            executeMemoryControl.stall   = 1'b1;
            memoryWritebackControl.flush = 1'b1;
            redirectHeld_d = redirectHeld_q | (pcSelect == PC_BRANCH);
          end else begin
            redirectHeld_d = 1'b0;
            if (loadUseHazard) begin
              fetchDecodeControl.stall   = 1'b1;
              decodeExecuteControl.flush = 1'b1;
            end else if (!imemReady) begin
              fetchDecodeControl.flush = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        fetchDecodeControl     = CTL_FLUSH;
        decodeExecuteControl   = CTL_FLUSH;
        executeMemoryControl   = CTL_FLUSH;
        memoryWritebackControl = CTL_FLUSH;
        redirectHeld_d         = 1'b0;
        cntEn                  = 1'b1;
        if (expired)              timeout_d = 1'b1;
        if (!dmemBusy || expired) state_d   = TRAP;
      end
      TRAP: begin
        pcSelect             = PC_TRAP;
        redirectValid        = 1'b1;
        trapCommit           = 1'b1;
        fetchDecodeControl   = CTL_FLUSH;
        decodeExecuteControl = CTL_FLUSH;
        executeMemoryControl = CTL_FLUSH;
        redirectHeld_d       = 1'b0;
        cntClr               = 1'b1;
        state_d              = RUN;
      end
      default: state_d = RUN;
    endcase

    if (!reset) begin
      fetchDecodeControl     = CTL_FLUSH;
      decodeExecuteControl   = CTL_FLUSH;
      executeMemoryControl   = CTL_FLUSH;
      memoryWritebackControl = CTL_FLUSH;
      pcSelect               = PC_SEQ;
      redirectValid          = 1'b0;
      trapCommit             = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= RUN;
      redirectHeld_q <= 1'b0;
      cause_q        <= '0;
      epc_q          <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      redirectHeld_q <= redirectHeld_d;
      cause_q        <= cause_d;
      epc_q          <= epc_d;
      timeout_q      <= timeout_d;
    end
  end

  assign trapCause    = cause_q;
  assign trapEPC      = epc_q;
  assign drainTimeout = timeout_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: vector table plus multi-cycle trap/drain sequences.
module tb_pipeline_controller;
  import pipeline_controller_pkg::*;

  logic        clock = 1'b0;
  logic        reset, loadUseHazard, branchValid, mretSignal, commitIllegal;
  logic [31:0] commitPC;
  logic        interrupt, interruptEnabled, imemReady, dmemBusy;
  control      fdc, dec, emc, mwc;
  pcSelect_    pcSelect;
  logic        redirectValid, trapCommit, drainTimeout;
  logic [31:0] trapCause, trapEPC;

  int unsigned tests = 0;
  int unsigned fails = 0;

  pipeline_controller #(.DRAIN_TIMEOUT(64)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .loadUseHazard          (loadUseHazard),
    .branchValid            (branchValid),
    .mretSignal             (mretSignal),
    .commitIllegal          (commitIllegal),
    .commitPC               (commitPC),
    .interrupt              (interrupt),
    .interruptEnabled       (interruptEnabled),
    .imemReady              (imemReady),
    .dmemBusy               (dmemBusy),
    .fetchDecodeControl     (fdc),
    .decodeExecuteControl   (dec),
    .executeMemoryControl   (emc),
    .memoryWritebackControl (mwc),
    .pcSelect               (pcSelect),
    .redirectValid          (redirectValid),
    .trapCommit             (trapCommit),
    .trapCause              (trapCause),
    .trapEPC                (trapEPC),
    .drainTimeout           (drainTimeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       lu, br, mr, busy, imr;
    logic [7:0] ctl;  // {IF/ID, ID/EX, EX/MEM, MEM/WB} each {stall, flush}
    pcSelect_   pc;
    logic       rv;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    loadUseHazard = 0; branchValid = 0; mretSignal = 0; commitIllegal = 0;
    commitPC = 32'h0; interrupt = 0; interruptEnabled = 0; imemReady = 1; dmemBusy = 0;
  endtask

  function automatic logic [7:0] ctl();
    return {fdc, dec, emc, mwc};
  endfunction

  int unsigned rvCount, emStalls, drainCycles;
  logic seen;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00_00_00_00, PC_SEQ,    1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b10_01_00_00, PC_SEQ,    1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b01_00_00_00, PC_SEQ,    1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b10_10_10_01, PC_SEQ,    1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'b01_01_00_00, PC_BRANCH, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'b01_01_00_00, PC_MRET,   1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'b01_01_00_00, PC_MRET,   1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10_01_00_00, PC_SEQ,    1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'b10_10_10_01, PC_SEQ,    1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'b11_01_00_00, PC_BRANCH, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b11_11_10_01, PC_MRET,   1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'b00_00_00_00, PC_SEQ,    1'b0};

    idle();
    reset = 0;
    cyc(); cyc(); #2;
    chk("rst_ctl",   32'(ctl()), 32'h55);
    chk("rst_rv",    32'(redirectValid), 0);
    chk("rst_tc",    32'(trapCommit), 0);
    chk("rst_pc",    32'(pcSelect), 32'(PC_SEQ));
    chk("rst_cause", trapCause, 0);
    chk("rst_epc",   trapEPC, 0);
    chk("rst_dto",   32'(drainTimeout), 0);
    cyc(); reset = 1;

    foreach (vecs[i]) begin
      cyc();
      loadUseHazard = vecs[i].lu; branchValid = vecs[i].br; mretSignal = vecs[i].mr;
      dmemBusy = vecs[i].busy; imemReady = vecs[i].imr;
      #2;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_pc", i),  32'(pcSelect), 32'(vecs[i].pc));
      chk($sformatf("vec%0d_rv", i),  32'(redirectValid), 32'(vecs[i].rv));
    end

    // load-use bubble lasts exactly one cycle
    cyc(); idle(); loadUseHazard = 1; #2;
    chk("lu_ctl", 32'(ctl()), 32'b10_01_00_00);
    cyc(); idle(); #2;
    chk("lu_next", 32'(ctl()), 0);

    // branch while dmemBusy for 3 cycles: one redirect, EX/MEM stalled 3
    rvCount = 0; emStalls = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(); idle(); branchValid = 1; dmemBusy = 1; #2;
      rvCount += 32'(redirectValid);
      emStalls += 32'(emc.stall);
    end
    chk("held_rv_count", rvCount, 1);
    chk("held_em_stalls", emStalls, 3);
    cyc(); idle(); #2;
    chk("held_release_em", 32'(emc), 0);
    cyc(); idle(); branchValid = 1; #2;
    chk("held_cleared_rv", 32'(redirectValid), 1);

    // illegal instruction, no drain
    cyc(); idle(); commitIllegal = 1; commitPC = 32'h100; #2;
    chk("ill_flush", 32'(ctl()), 32'h55);
    chk("ill_rv", 32'(redirectValid), 0);
    cyc(); idle(); #2;
    chk("ill_tc", 32'(trapCommit), 1);
    chk("ill_pc", 32'(pcSelect), 32'(PC_TRAP));
    chk("ill_rv2", 32'(redirectValid), 1);
    chk("ill_cause", trapCause, 32'd2);
    chk("ill_epc", trapEPC, 32'h100);
    chk("ill_ctl", 32'(ctl()), 32'b01_01_01_00);
    cyc(); idle(); #2;
    chk("ill_tc_once", 32'(trapCommit), 0);

    // trap and branch same cycle: trap wins
    cyc(); idle(); commitIllegal = 1; branchValid = 1; commitPC = 32'h200; #2;
    chk("tb_rv", 32'(redirectValid), 0);
    chk("tb_pc", 32'(pcSelect), 32'(PC_SEQ));
    cyc(); idle(); #2;
    chk("tb_tc", 32'(trapCommit), 1);
    chk("tb_epc", trapEPC, 32'h200);

    // trap with dmemBusy held 5 cycles -> 5 DRAIN cycles
    cyc(); idle(); commitIllegal = 1; commitPC = 32'h300; dmemBusy = 1; #2;
    drainCycles = 0; seen = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      cyc(); idle(); dmemBusy = (n < 5); #2;
      if (trapCommit) seen = 1;
      else begin
        drainCycles++;
        chk($sformatf("drain_rv%0d", n), 32'(redirectValid), 0);
        chk($sformatf("drain_ctl%0d", n), 32'(ctl()), 32'h55);
      end
    end
    chk("drain5_seen", 32'(seen), 1);
    chk("drain5_cycles", drainCycles, 5);
    chk("drain5_dto", 32'(drainTimeout), 0);
    chk("drain5_epc", trapEPC, 32'h300);

    // dmemBusy stuck -> forced trap after 64 DRAIN cycles
    cyc(); idle(); commitIllegal = 1; commitPC = 32'h400; dmemBusy = 1; #2;
    drainCycles = 0; seen = 0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      cyc(); idle(); dmemBusy = 1; #2;
      if (trapCommit) seen = 1;
      else drainCycles++;
    end
    chk("stuck_seen", 32'(seen), 1);
    chk("stuck_cycles", drainCycles, 64);
    chk("stuck_dto", 32'(drainTimeout), 1);
    cyc(); idle(); #2;
    chk("stuck_dto_sticky", 32'(drainTimeout), 1);

    // reset in the middle of DRAIN returns to RUN
    cyc(); idle(); commitIllegal = 1; dmemBusy = 1; #2;
    cyc(); idle(); dmemBusy = 1; #2;
    cyc(); idle(); reset = 0; #2;
    chk("rd_rst_ctl", 32'(ctl()), 32'h55);
    cyc(); idle(); reset = 1; #2;
    chk("rd_tc", 32'(trapCommit), 0);
    chk("rd_dto", 32'(drainTimeout), 0);
    chk("rd_cause", trapCause, 0);
    cyc(); idle(); #2;
    chk("rd_tc2", 32'(trapCommit), 0);

    // interrupt disabled by enable bit never traps
    cyc(); idle(); interrupt = 1; interruptEnabled = 0; #2;
    cyc(); idle(); #2;
    chk("irq_masked_tc", 32'(trapCommit), 0);

    cyc(); idle(); interrupt = 1; interruptEnabled = 1; commitPC = 32'h500; #2;
    cyc(); idle(); #2;
`ifdef PIPECTL_INTERRUPT_EN
    chk("irq_tc", 32'(trapCommit), 1);
    chk("irq_cause", trapCause, 32'h8000000B);
    chk("irq_epc", trapEPC, 32'h500);
`else
    chk("irq_off_tc", 32'(trapCommit), 0);
    chk("irq_off_cause", trapCause, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
